regfile_param: RTL and testbench



---
 rtl/regfile_param.sv | 142 ++++++++++++++
 tb/tb_regfile_param.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_param.sv
// -----------------------------------------------------------------------------
// regfile_param
// Parametrised integer register file: two combinational read ports, one
// synchronous write port, optional same-cycle write-to-read bypass, an
// asynchronous clear on reset and a sequenced clear engine that zeroes one
// register per cycle. A third read-only debug port always shows stored state.
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   RegWEn    in   write enable
//   rd_addr   in   write address
//   rd_data   in   write data
//   rs1_addr  in   read port 1 address
//   rs2_addr  in   read port 2 address
//   rs1_data  out  read port 1 data (combinational, may be bypassed)
//   rs2_data  out  read port 2 data (combinational, may be bypassed)
//   dbg_addr  in   debug read address
//   dbg_data  out  debug read data (combinational, never bypassed)
//   clr_req   in   request a full sequenced clear
//   clr_busy  out  clear sweep in progress
//   clr_done  out  one-cycle pulse when the sweep completes
// -----------------------------------------------------------------------------
module regfile_param #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NREG     = 32,
    parameter bit          BYPASS   = 1'b1,
    parameter bit          ZERO_REG = 1'b1,
    localparam int unsigned AW      = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            RegWEn,
    input  logic [AW-1:0]   rd_addr,
    input  logic [XLEN-1:0] rd_data,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic [AW-1:0]   dbg_addr,
    output logic [XLEN-1:0] dbg_data,
    input  logic            clr_req,
    output logic            clr_busy,
    output logic            clr_done
);

    typedef enum logic [1:0] {
        StIdle,
        StClear,
        StDone
    } state_e;

    state_e          r_state;
    state_e          w_state_next;
    logic [AW-1:0]   r_cnt;
    logic [AW-1:0]   w_cnt_next;
    logic [XLEN-1:0] r_regs [NREG];
    logic            w_wr_en;

    // An address is usable if it maps to a real register that is not the
    // hardwired zero register. Compared at 32 bits so NREG == 2**AW works.
    function automatic logic f_legal(input logic [AW-1:0] a);
        return (32'(a) < NREG) && !(ZERO_REG && (a == '0));
    endfunction

    function automatic logic [XLEN-1:0] f_stored(input logic [AW-1:0] a);
        return f_legal(a) ? r_regs[a] : '0;
    endfunction

    assign clr_busy = (r_state == StClear);
    assign clr_done = (r_state == StDone);
    assign w_wr_en  = RegWEn && !clr_busy && f_legal(rd_addr);

    // Bypass uses w_wr_en, so it is automatically off during a sweep and for
    // illegal write addresses.
    always_comb begin
        rs1_data = f_stored(rs1_addr);
        rs2_data = f_stored(rs2_addr);
        dbg_data = f_stored(dbg_addr);
        if (BYPASS && w_wr_en && (rd_addr == rs1_addr)) begin
            rs1_data = rd_data;
        end
        if (BYPASS && w_wr_en && (rd_addr == rs2_addr)) begin
            rs2_data = rd_data;
        end
    end

    // Storage: write port and sweep are mutually exclusive (w_wr_en needs !busy).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREG); i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (w_wr_en) begin
                r_regs[rd_addr] <= rd_data;
            end
            if (r_state == StClear) begin
                r_regs[r_cnt] <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        unique case (r_state)
            StIdle: begin
                if (clr_req) begin
                    w_state_next = StClear;
                    w_cnt_next   = '0;
                end
            end
            StClear: begin
                w_cnt_next = r_cnt + AW'(1);
                if (32'(r_cnt) == NREG - 1) begin
                    w_state_next = StDone;
                    w_cnt_next   = '0;
                end
            end
            StDone: begin
                // clr_req ignored here so back-to-back sweeps see the DONE cycle.
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
                w_cnt_next   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_regfile_param.sv
module tb_regfile_param;

    logic        clk;
    logic        rst_n;
    logic        RegWEn;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  dbg_addr;
    logic        clr_req;

    logic [31:0] a_rs1, a_rs2, a_dbg;
    logic        a_busy, a_done;
    logic [31:0] b_rs1, b_rs2, b_dbg;
    logic        b_busy, b_done;

    int checks;
    int errors;

    // Reference model: index 0 = default DUT, index 1 = 24-deep, no bypass, no zero reg.
    logic [31:0] mem [2][32];
    int          nreg [2];
    bit          byp [2];
    bit          zr [2];
    int          phase [2];   // 0 idle, 1 sweeping, 2 done cycle
    int          idx [2];

    regfile_param #(.XLEN(32), .NREG(32), .BYPASS(1'b1), .ZERO_REG(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .RegWEn(RegWEn), .rd_addr(rd_addr), .rd_data(rd_data),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(a_rs1), .rs2_data(a_rs2),
        .dbg_addr(dbg_addr), .dbg_data(a_dbg), .clr_req(clr_req), .clr_busy(a_busy),
        .clr_done(a_done)
    );

    regfile_param #(.XLEN(32), .NREG(24), .BYPASS(1'b0), .ZERO_REG(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .RegWEn(RegWEn), .rd_addr(rd_addr), .rd_data(rd_data),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(b_rs1), .rs2_data(b_rs2),
        .dbg_addr(dbg_addr), .dbg_data(b_dbg), .clr_req(clr_req), .clr_busy(b_busy),
        .clr_done(b_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit legal(int d, logic [4:0] a);
        return (int'(a) < nreg[d]) && !(zr[d] && (a == 5'd0));
    endfunction

    function automatic logic [31:0] exp_dbg(int d, logic [4:0] a);
        return legal(d, a) ? mem[d][a] : 32'h0;
    endfunction

    function automatic logic [31:0] exp_rs(int d, logic [4:0] a);
        if (byp[d] && RegWEn && phase[d] != 1 && legal(d, rd_addr) && rd_addr == a)
            return rd_data;
        return exp_dbg(d, a);
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 32; i++) mem[d][i] = 32'h0;
            phase[d] = 0;
            idx[d]   = 0;
        end
    endtask

    // Advance one clock edge and apply the spec rules to the model.
    task automatic step();
        @(posedge clk);
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                case (phase[d])
                    1: begin
                        mem[d][idx[d]] = 32'h0;
                        idx[d]++;
                        if (idx[d] == nreg[d]) phase[d] = 2;
                    end
                    2: begin
                        if (RegWEn && legal(d, rd_addr)) mem[d][rd_addr] = rd_data;
                        phase[d] = 0;
                    end
                    default: begin
                        if (RegWEn && legal(d, rd_addr)) mem[d][rd_addr] = rd_data;
                        if (clr_req) begin
                            phase[d] = 1;
                            idx[d]   = 0;
                        end
                    end
                endcase
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        #2;
        for (int a = 0; a < 32; a++) begin
            dbg_addr = 5'(a);
            #1;
            checks += 2;
            if (a_dbg !== 32'h0) begin
                errors++;
                $display("FAIL reset_dbg_a addr %0d got %h exp 0", a, a_dbg);
            end
            if (b_dbg !== 32'h0) begin
                errors++;
                $display("FAIL reset_dbg_b addr %0d got %h exp 0", a, b_dbg);
            end
        end
        checks += 2;
        if (a_busy !== 1'b0 || a_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags_a got busy %b done %b exp 0 0", a_busy, a_done);
        end
        if (b_busy !== 1'b0 || b_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags_b got busy %b done %b exp 0 0", b_busy, b_done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_write_read();
        RegWEn = 1'b1; rd_addr = 5'd5; rd_data = 32'hDEADBEEF;
        step();
        RegWEn = 1'b0; rs1_addr = 5'd5; rs2_addr = 5'd0;
        #1;
        checks += 3;
        if (a_rs1 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL wr_rd_a_rs1 got %h exp deadbeef", a_rs1);
        end
        if (a_rs2 !== 32'h0) begin
            errors++;
            $display("FAIL wr_rd_a_rs2 got %h exp 0", a_rs2);
        end
        if (b_rs1 !== exp_rs(1, 5'd5)) begin
            errors++;
            $display("FAIL wr_rd_b_rs1 got %h exp %h", b_rs1, exp_rs(1, 5'd5));
        end
    endtask

    task automatic test_bypass();
        RegWEn = 1'b1; rd_addr = 5'd7; rd_data = 32'hAAAA0007;
        step();
        rd_data = 32'h1234; rs1_addr = 5'd7; dbg_addr = 5'd7;
        #1;
        checks += 4;
        if (a_rs1 !== 32'h1234) begin
            errors++;
            $display("FAIL bypass_a_rs1 got %h exp 00001234", a_rs1);
        end
        if (a_dbg !== 32'hAAAA0007) begin
            errors++;
            $display("FAIL bypass_a_dbg got %h exp aaaa0007", a_dbg);
        end
        if (b_rs1 !== 32'hAAAA0007) begin
            errors++;
            $display("FAIL nobypass_b_rs1 got %h exp aaaa0007", b_rs1);
        end
        if (b_dbg !== 32'hAAAA0007) begin
            errors++;
            $display("FAIL nobypass_b_dbg got %h exp aaaa0007", b_dbg);
        end
        step();
        RegWEn = 1'b0;
        #1;
        checks += 2;
        if (a_rs1 !== 32'h1234 || b_rs1 !== 32'h1234) begin
            errors++;
            $display("FAIL bypass_commit got a %h b %h exp 00001234", a_rs1, b_rs1);
        end
        if (a_dbg !== 32'h1234) begin
            errors++;
            $display("FAIL bypass_commit_dbg got %h exp 00001234", a_dbg);
        end
    endtask

    task automatic test_zero_reg();
        RegWEn = 1'b1; rd_addr = 5'd0; rd_data = 32'hFFFFFFFF; rs1_addr = 5'd0;
        #1;
        checks += 2;
        if (a_rs1 !== 32'h0) begin
            errors++;
            $display("FAIL zero_bypass_a got %h exp 0", a_rs1);
        end
        if (b_rs1 !== 32'h0) begin
            errors++;
            $display("FAIL zero_prewrite_b got %h exp 0", b_rs1);
        end
        step();
        RegWEn = 1'b0;
        #1;
        checks += 2;
        if (a_rs1 !== 32'h0) begin
            errors++;
            $display("FAIL zero_stored_a got %h exp 0", a_rs1);
        end
        if (b_rs1 !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL nozero_stored_b got %h exp ffffffff", b_rs1);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            RegWEn   = 1'($urandom_range(0, 1));
            rd_addr  = 5'($urandom_range(0, 31));
            rd_data  = $urandom;
            rs1_addr = ($urandom_range(0, 3) == 0) ? rd_addr : 5'($urandom_range(0, 31));
            rs2_addr = 5'($urandom_range(0, 31));
            dbg_addr = 5'($urandom_range(0, 31));
            clr_req  = ($urandom_range(0, 59) == 0);
            #1;
            for (int d = 0; d < 2; d++) begin
                logic [31:0] g1, g2, gd;
                logic        gb, gn;
                g1 = (d == 0) ? a_rs1 : b_rs1;
                g2 = (d == 0) ? a_rs2 : b_rs2;
                gd = (d == 0) ? a_dbg : b_dbg;
                gb = (d == 0) ? a_busy : b_busy;
                gn = (d == 0) ? a_done : b_done;
                checks += 4;
                if (g1 !== exp_rs(d, rs1_addr)) begin
                    errors++;
                    $display("FAIL rand_rs1 dut%0d addr %0d got %h exp %h",
                             d, rs1_addr, g1, exp_rs(d, rs1_addr));
                end
                if (g2 !== exp_rs(d, rs2_addr)) begin
                    errors++;
                    $display("FAIL rand_rs2 dut%0d addr %0d got %h exp %h",
                             d, rs2_addr, g2, exp_rs(d, rs2_addr));
                end
                if (gd !== exp_dbg(d, dbg_addr)) begin
                    errors++;
                    $display("FAIL rand_dbg dut%0d addr %0d got %h exp %h",
                             d, dbg_addr, gd, exp_dbg(d, dbg_addr));
                end
                if (gb !== (phase[d] == 1) || gn !== (phase[d] == 2)) begin
                    errors++;
                    $display("FAIL rand_flags dut%0d got busy %b done %b exp %b %b",
                             d, gb, gn, phase[d] == 1, phase[d] == 2);
                end
            end
            step();
        end
        RegWEn = 1'b0; clr_req = 1'b0;
        for (int n = 0; n < 40; n++) step();
    endtask

    task automatic test_clear();
        int busy_a, busy_b, done_a, done_b;
        for (int i = 1; i < 32; i++) begin
            RegWEn = 1'b1; rd_addr = 5'(i); rd_data = i * 32'h11;
            step();
        end
        RegWEn = 1'b0; clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        busy_a = 0; busy_b = 0; done_a = 0; done_b = 0;
        for (int k = 1; k <= 40; k++) begin
            RegWEn   = (k == 5) || (k == 33);
            rd_addr  = (k == 5) ? 5'd3 : 5'd4;
            rd_data  = (k == 5) ? 32'h33333333 : 32'h55;
            rs1_addr = rd_addr;
            rs2_addr = 5'($urandom_range(0, 31));
            dbg_addr = 5'($urandom_range(0, 31));
            #1;
            busy_a += int'(a_busy); busy_b += int'(b_busy);
            done_a += int'(a_done); done_b += int'(b_done);
            checks += 6;
            if (a_busy !== (k <= 32) || a_done !== (k == 33)) begin
                errors++;
                $display("FAIL clr_flags_a cycle %0d got busy %b done %b exp %b %b",
                         k, a_busy, a_done, k <= 32, k == 33);
            end
            if (b_busy !== (k <= 24) || b_done !== (k == 25)) begin
                errors++;
                $display("FAIL clr_flags_b cycle %0d got busy %b done %b exp %b %b",
                         k, b_busy, b_done, k <= 24, k == 25);
            end
            if (a_rs1 !== exp_rs(0, rs1_addr) || b_rs1 !== exp_rs(1, rs1_addr)) begin
                errors++;
                $display("FAIL clr_rs1 cycle %0d got %h %h exp %h %h", k, a_rs1, b_rs1,
                         exp_rs(0, rs1_addr), exp_rs(1, rs1_addr));
            end
            if (a_rs2 !== exp_rs(0, rs2_addr) || b_rs2 !== exp_rs(1, rs2_addr)) begin
                errors++;
                $display("FAIL clr_rs2 cycle %0d got %h %h exp %h %h", k, a_rs2, b_rs2,
                         exp_rs(0, rs2_addr), exp_rs(1, rs2_addr));
            end
            if (a_dbg !== exp_dbg(0, dbg_addr)) begin
                errors++;
                $display("FAIL clr_dbg_a cycle %0d got %h exp %h", k, a_dbg,
                         exp_dbg(0, dbg_addr));
            end
            if (b_dbg !== exp_dbg(1, dbg_addr)) begin
                errors++;
                $display("FAIL clr_dbg_b cycle %0d got %h exp %h", k, b_dbg,
                         exp_dbg(1, dbg_addr));
            end
            step();
        end
        RegWEn = 1'b0;
        checks += 2;
        if (busy_a != 32 || done_a != 1) begin
            errors++;
            $display("FAIL clr_len_a got busy %0d done %0d exp 32 1", busy_a, done_a);
        end
        if (busy_b != 24 || done_b != 1) begin
            errors++;
            $display("FAIL clr_len_b got busy %0d done %0d exp 24 1", busy_b, done_b);
        end
        dbg_addr = 5'd3;
        #1;
        checks += 1;
        if (a_dbg !== 32'h0 || b_dbg !== 32'h0) begin
            errors++;
            $display("FAIL clr_drop_x3 got %h %h exp 0 0", a_dbg, b_dbg);
        end
        dbg_addr = 5'd4;
        #1;
        checks += 1;
        if (a_dbg !== 32'h55 || b_dbg !== 32'h55) begin
            errors++;
            $display("FAIL clr_done_write_x4 got %h %h exp 55 55", a_dbg, b_dbg);
        end
    endtask

    task automatic test_reset_mid_sweep();
        RegWEn = 1'b1; rd_addr = 5'd20; rd_data = 32'h99;
        step();
        RegWEn = 1'b0; clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        for (int k = 1; k < 10; k++) step();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks += 1;
        if (a_busy !== 1'b0 || b_busy !== 1'b0 || a_done !== 1'b0 || b_done !== 1'b0) begin
            errors++;
            $display("FAIL midrst_flags got busy %b %b done %b %b exp 0", a_busy, b_busy,
                     a_done, b_done);
        end
        dbg_addr = 5'd20;
        #1;
        checks += 1;
        if (a_dbg !== 32'h0 || b_dbg !== 32'h0) begin
            errors++;
            $display("FAIL midrst_x20 got %h %h exp 0 0", a_dbg, b_dbg);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 40; k++) begin
            checks += 1;
            if (a_done !== 1'b0 || b_done !== 1'b0 || a_busy !== 1'b0 || b_busy !== 1'b0) begin
                errors++;
                $display("FAIL midrst_no_done cycle %0d got done %b %b busy %b %b exp 0",
                         k, a_done, b_done, a_busy, b_busy);
            end
            step();
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        nreg[0] = 32; byp[0] = 1'b1; zr[0] = 1'b1;
        nreg[1] = 24; byp[1] = 1'b0; zr[1] = 1'b0;
        rst_n = 1'b0; RegWEn = 1'b0; rd_addr = '0; rd_data = '0;
        rs1_addr = '0; rs2_addr = '0; dbg_addr = '0; clr_req = 1'b0;
        model_reset();
        test_reset();
        test_write_read();
        test_bypass();
        test_zero_reg();
        test_random();
        test_clear();
        test_reset_mid_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
